// File: rtl/raw_data_arb_pkg.sv
// Shared types and defaults for the raw-data output arbiter.
// Four encode lanes compete for one shared output FIFO.
package raw_data_arb_pkg;

    localparam int NUM_LANES       = 4;
    localparam int LANE_W          = $clog2(NUM_LANES);
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MAX_BURST   = 4;
    localparam int DEF_STALL_LIMIT = 16;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        XFER = 2'd2,
        FULL = 2'd3
    } arb_state_t;

endpackage

// File: rtl/raw_data_out_arbiter_rr_pick.sv
// Round-robin picker: first requesting lane at or above rr_ptr, wrapping modulo the lane count.
module rr_pick
    import raw_data_arb_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    rr_ptr,
    output logic                 valid,
    output logic [LANE_W-1:0]    index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!valid && req[LANE_W'(rr_ptr + LANE_W'(k))]) begin
                valid = 1'b1;
                index = LANE_W'(rr_ptr + LANE_W'(k));
            end
        end
    end

endmodule

// File: rtl/raw_data_out_arbiter.sv
// Grants the shared output FIFO to one encode lane at a time, in bursts of up to MAX_BURST words,
// with round-robin fairness and a forced release when the owning lane goes quiet for too long.
module raw_data_out_arbiter
    import raw_data_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LANES-1:0]          req,
    input  logic [NUM_LANES-1:0]          req_last,
    input  logic [NUM_LANES*DATA_W-1:0]   req_data,
    output logic [NUM_LANES-1:0]          grant,
    input  logic                          out_fifo_full,
    output logic                          out_fifo_push,
    output logic [DATA_W-1:0]             out_fifo_data,
    output logic                          out_fifo_clr,
    output logic [LANE_W-1:0]             owner,
    output logic                          stall_err
);

    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    arb_state_t           state, state_nxt;
    logic [LANE_W-1:0]    owner_q, owner_nxt;
    logic [LANE_W-1:0]    rr_ptr, rr_nxt;
    logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
    logic [STALL_W-1:0]   stall_cnt, stall_nxt;
    logic                 pick_valid;
    logic [LANE_W-1:0]    pick_idx;
    logic [DATA_W-1:0]    owner_word;
    logic [LANE_W-1:0]    owner_plus1;

    rr_pick u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    assign owner_word  = req_data[owner_q*DATA_W +: DATA_W];
    assign owner_plus1 = owner_q + LANE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            owner_q   <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner_q   <= owner_nxt;
            rr_ptr    <= rr_nxt;
            beat_cnt  <= beat_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner_q;
        rr_nxt        = rr_ptr;
        beat_nxt      = beat_cnt;
        stall_nxt     = stall_cnt;
        grant         = '0;
        out_fifo_push = 1'b0;
        out_fifo_data = '0;
        out_fifo_clr  = 1'b0;
        owner         = '0;
        stall_err     = 1'b0;

        case (state)
            INIT: begin
                out_fifo_clr = 1'b1;
                owner_nxt    = '0;
                rr_nxt       = '0;
                beat_nxt     = '0;
                stall_nxt    = '0;
                state_nxt    = IDLE;
            end
            IDLE: begin
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    beat_nxt  = '0;
                    stall_nxt = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                owner = owner_q;
                if (out_fifo_full) begin
                    state_nxt = FULL;
                end else if (req[owner_q]) begin
                    out_fifo_push  = 1'b1;
                    grant[owner_q] = 1'b1;
                    out_fifo_data  = owner_word;
                    stall_nxt      = '0;
                    if (req_last[owner_q] || beat_cnt == BEAT_LAST) begin
                        rr_nxt    = owner_plus1;
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        beat_nxt = beat_cnt + BEAT_W'(1);
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    // Owner went quiet: give the FIFO back so other lanes are not starved.
                    stall_err = 1'b1;
                    rr_nxt    = owner_plus1;
                    beat_nxt  = '0;
                    stall_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    stall_nxt = stall_cnt + STALL_W'(1);
                end
            end
            FULL: begin
                owner = owner_q;
                if (!out_fifo_full) begin
                    state_nxt = XFER;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase

        // Reset takes effect on the outputs immediately, so an interrupted burst never pushes again.
        if (reset) begin
            grant         = '0;
            out_fifo_push = 1'b0;
            out_fifo_data = '0;
            out_fifo_clr  = 1'b1;
            owner         = '0;
            stall_err     = 1'b0;
        end
    end

endmodule

// File: tb/tb_raw_data_out_arbiter.sv
// Self-checking bench: lanes drain word queues into the arbiter; a transaction-level model predicts
// the push order, and a monitor compares every FIFO push against that prediction.
module tb_raw_data_out_arbiter;

    localparam int DW          = 32;
    localparam int NL          = 4;
    localparam int MAX_BURST   = 4;
    localparam int STALL_LIMIT = 16;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NL-1:0]    req = '0;
    logic [NL-1:0]    req_last = '0;
    logic [NL*DW-1:0] req_data = '0;
    logic             out_fifo_full = 1'b0;
    logic [NL-1:0]    grant;
    logic             out_fifo_push;
    logic [DW-1:0]    out_fifo_data;
    logic             out_fifo_clr;
    logic [1:0]       owner;
    logic             stall_err;

    logic [DW-1:0] lane_q    [NL][$];
    bit            lane_last [NL][$];
    exp_t          exp_q[$];
    int            push_cycles[$];
    bit            full_sched[$];
    int            full_pct = 0;
    int            model_ptr = 0;
    int            cyc_cnt = 0;
    int            total = 0;
    int            bad = 0;
    logic [NL-1:0] seen_grant;
    logic          seen_err;

    raw_data_out_arbiter #(
        .DATA_W      (DW),
        .MAX_BURST   (MAX_BURST),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_last      (req_last),
        .req_data      (req_data),
        .grant         (grant),
        .out_fifo_full (out_fifo_full),
        .out_fifo_push (out_fifo_push),
        .out_fifo_data (out_fifo_data),
        .out_fifo_clr  (out_fifo_clr),
        .owner         (owner),
        .stall_err     (stall_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc_cnt);
        end
    endtask

    function automatic bit lanesBusy();
        bit busy = 1'b0;
        for (int i = 0; i < NL; i++) busy |= (lane_q[i].size() > 0);
        return busy;
    endfunction

    task automatic addBurst(input int lane, input int len, input bit use_last);
        for (int j = 0; j < len; j++) begin
            lane_q[lane].push_back($urandom);
            lane_last[lane].push_back(use_last && (j == len - 1));
        end
    endtask

    task automatic clearLanes();
        for (int i = 0; i < NL; i++) begin
            lane_q[i].delete();
            lane_last[i].delete();
        end
    endtask

    task automatic driveLanes();
        for (int i = 0; i < NL; i++) begin
            if (lane_q[i].size() > 0) begin
                req[i]               = 1'b1;
                req_last[i]          = lane_last[i][0];
                req_data[i*DW +: DW] = lane_q[i][0];
            end else begin
                req[i]               = 1'b0;
                req_last[i]          = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW] = $urandom;
            end
        end
    endtask

    // Burst-level model: round-robin over lanes holding words; a burst ends on last, on the
    // word limit, or when the lane runs dry (which the arbiter resolves by forced release).
    task automatic buildExpected();
        logic [DW-1:0] cq [NL][$];
        bit            cl [NL][$];
        exp_t          e;
        int            l;
        int            n;
        bit            done;
        for (int i = 0; i < NL; i++) begin
            cq[i] = lane_q[i];
            cl[i] = lane_last[i];
        end
        forever begin
            l = -1;
            for (int k = 0; k < NL; k++)
                if (l < 0 && cq[(model_ptr + k) % NL].size() > 0) l = (model_ptr + k) % NL;
            if (l < 0) break;
            n = 0;
            done = 1'b0;
            while (!done) begin
                e.lane = l;
                e.data = cq[l].pop_front();
                exp_q.push_back(e);
                done = cl[l].pop_front() || (n == MAX_BURST - 1) || (cq[l].size() == 0);
                n++;
            end
            model_ptr = (l + 1) % NL;
        end
    endtask

    task automatic stepCycle();
        driveLanes();
        if (full_sched.size() > 0) out_fifo_full = full_sched.pop_front();
        else out_fifo_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
        @(negedge clk);
        seen_grant = grant;
        seen_err   = stall_err;
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (seen_grant[i] && lane_q[i].size() > 0) begin
                void'(lane_q[i].pop_front());
                void'(lane_last[i].pop_front());
            end
        end
    endtask

    task automatic applyStimulus(input int budget);
        int cyc = 0;
        while ((lanesBusy() || exp_q.size() != 0) && cyc < budget) begin
            stepCycle();
            cyc++;
        end
        checkOutput("scenario_drained", 64'(lanesBusy() || exp_q.size() != 0), 0);
        out_fifo_full = 1'b0;
        driveLanes();
    endtask

    task automatic resetDut();
        driveLanes();
        out_fifo_full = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_clr", out_fifo_clr, 1);
        checkOutput("rst_push", out_fifo_push, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_stall_err", stall_err, 0);
        checkOutput("rst_data", out_fifo_data, 0);
        @(posedge clk);
        #1;
        clearLanes();
        driveLanes();
        exp_q.delete();
        model_ptr = 0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("init_clr", out_fifo_clr, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("idle_clr", out_fifo_clr, 0);
        checkOutput("idle_grant", grant, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (out_fifo_full && !reset) checkOutput("push_while_full", out_fifo_push, 0);
            if (out_fifo_push) begin
                push_cycles.push_back(cyc_cnt);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_push actual=data %0h grant %b required=no push (cycle %0d)",
                             out_fifo_data, grant, cyc_cnt);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("push_data", out_fifo_data, e.data);
                    checkOutput("push_grant", grant, 64'(1) << e.lane);
                    checkOutput("push_owner", owner, e.lane);
                end
            end else begin
                checkOutput("grant_without_push", grant, 0);
            end
        end
    endtask

    initial begin
        int base;
        int n;
        bit any;

        fork
            monitorLoop();
        join_none

        // Reset with every lane requesting: outputs must still be quiet.
        for (int i = 0; i < NL; i++) addBurst(i, 2, 1'b0);
        resetDut();

        // All four lanes, no last flag: four full bursts in lane order.
        for (int i = 0; i < NL; i++) addBurst(i, 4, 1'b0);
        base = push_cycles.size();
        buildExpected();
        applyStimulus(100);
        checkOutput("rr4_push_count", push_cycles.size() - base, 16);
        if (push_cycles.size() - base == 16)
            checkOutput("rr4_span", push_cycles[base+15] - push_cycles[base], 18);

        // Lane 2 alone ending early on last, then lane 0.
        addBurst(2, 2, 1'b1);
        base = push_cycles.size();
        buildExpected();
        applyStimulus(50);
        checkOutput("lane2_push_count", push_cycles.size() - base, 2);
        addBurst(0, 3, 1'b1);
        buildExpected();
        applyStimulus(50);

        // Full for five cycles after lane 1's first word.
        addBurst(1, 4, 1'b1);
        buildExpected();
        base = push_cycles.size();
        for (int i = 0; i < 7; i++) full_sched.push_back(i >= 2);
        repeat (7) stepCycle();
        checkOutput("full_window_pushes", push_cycles.size() - base, 1);
        applyStimulus(50);
        checkOutput("full_total_pushes", push_cycles.size() - base, 4);

        // Lane 3 goes quiet after one word while lane 0 waits.
        addBurst(3, 1, 1'b0);
        buildExpected();
        applyStimulus(50);
        addBurst(0, 2, 1'b1);
        n = 0;
        seen_err = 1'b0;
        while (!seen_err && n < 40) begin
            stepCycle();
            n++;
        end
        checkOutput("stall_release_cycle", n, STALL_LIMIT);
        stepCycle();
        checkOutput("stall_pulse_width", seen_err, 0);
        buildExpected();
        applyStimulus(50);

        // Reset in the middle of a lane 1 burst.
        addBurst(1, 4, 1'b0);
        for (int j = 0; j < 2; j++) begin
            exp_t e;
            e.lane = 1;
            e.data = lane_q[1][j];
            exp_q.push_back(e);
        end
        repeat (3) stepCycle();
        checkOutput("mid_burst_pushes", exp_q.size(), 0);
        resetDut();
        addBurst(2, 2, 1'b1);
        addBurst(0, 2, 1'b1);
        base = push_cycles.size();
        buildExpected();
        applyStimulus(50);
        checkOutput("post_reset_push_count", push_cycles.size() - base, 4);

        // Randomised traffic with a randomly busy FIFO.
        full_pct = 30;
        for (int r = 0; r < 12; r++) begin
            any = 1'b0;
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    any = 1'b1;
                    for (int b = 0; b < int'($urandom_range(1, 2)); b++)
                        addBurst(i, int'($urandom_range(1, 6)), 1'b1);
                end
            end
            if (!any) addBurst(int'($urandom_range(0, NL - 1)), int'($urandom_range(1, 6)), 1'b1);
            buildExpected();
            applyStimulus(3000);
        end
        full_pct = 0;
        repeat (2) stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raw_data_out_arbiter.md
RAW_DATA_OUT_ARBITER -- requirements
Module: raw_data_out_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of one encoded word.
REQ-002 Parameter MAX_BURST, default 4: maximum words per grant, matching the four encode phases.
REQ-003 Parameter STALL_LIMIT, default 16: consecutive owner-idle cycles before forced release.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  4  per-lane request; lane i has a word valid this cycle.
REQ-007 req_last  input  4  per-lane flag; the current word ends lane i's burst.
REQ-008 req_data  input  4*DATA_W  per-lane word; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 grant  output  4  one-hot accept; grant[i]=1 means lane i's word is consumed this cycle.
REQ-010 out_fifo_full  input  1  shared output FIFO cannot accept a word.
REQ-011 out_fifo_push  output  1  write strobe to the shared output FIFO.
REQ-012 out_fifo_data  output  DATA_W  word written when out_fifo_push=1.
REQ-013 out_fifo_clr  output  1  clear strobe to the shared output FIFO.
REQ-014 owner  output  2  index of the lane currently holding the FIFO; 0 when none.
REQ-015 stall_err  output  1  one-cycle pulse on forced release.

Function
REQ-016 States SHALL be INIT, IDLE, XFER and FULL.
REQ-017 INIT SHALL assert out_fifo_clr, clear rr_ptr, beat_cnt and stall_cnt, and go to IDLE after one cycle.
REQ-018 IDLE SHALL pick the first requesting lane, searching round-robin from rr_ptr upward modulo 4.
  - The picked lane is latched as owner; state goes to XFER next cycle.
  - With no request, state stays IDLE.
  - IDLE never pushes or grants; first-word latency from req is one cycle.
REQ-019 In XFER with req[owner]=1 and out_fifo_full=0, the block SHALL assert these in the same cycle (combinational):
  - out_fifo_push=1 and grant[owner]=1.
  - out_fifo_data driven from lane owner.
  - beat_cnt incremented and stall_cnt cleared.
REQ-020 A push with req_last[owner]=1, or with beat_cnt=MAX_BURST-1, SHALL end the burst.
  - On burst end: rr_ptr <= owner+1 mod 4, beat_cnt <= 0, next state IDLE.
REQ-021 In XFER with out_fifo_full=1, the block SHALL go to FULL with no push and no grant; the word is not consumed.
REQ-022 FULL SHALL hold owner, beat_cnt and the outputs at zero, and return to XFER the cycle after out_fifo_full=0.
REQ-023 In XFER with req[owner]=0 and out_fifo_full=0, the block SHALL keep ownership and increment stall_cnt.
  - When stall_cnt reaches STALL_LIMIT-1: pulse stall_err, rr_ptr <= owner+1, go to IDLE.
  - stall_cnt does not count in FULL.
REQ-024 Requests from non-owner lanes SHALL be ignored until IDLE; grant is never asserted to more than one lane.
REQ-025 An illegal state encoding SHALL return to INIT on the next cycle.

Reset
REQ-026 While reset=1, state SHALL be forced to INIT: out_fifo_clr=1; grant, out_fifo_push and stall_err=0; owner=0; out_fifo_data=0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no further push, and resume with a one-cycle INIT clear.

Structure
REQ-028 Package raw_data_arb_pkg SHALL hold:
  - the state type;
  - NUM_LANES=4;
  - the default DATA_W, MAX_BURST and STALL_LIMIT values.
REQ-029 The round-robin picker (req, rr_ptr -> valid, index) SHALL be a separate combinational sub-module, rr_pick.

Verification
REQ-030 Reset, then idle -> out_fifo_clr high for exactly one cycle after reset drops, no grant while req=0.
REQ-031 req=4'b1111, no last -> four bursts of 4 words each, in owner order 0,1,2,3, with one IDLE cycle between bursts.
REQ-032 Lane 2 alone, req_last on word 2, full=0 -> 2 pushes, then rr_ptr=3; lane 0 requesting next is granted.
REQ-033 Full asserted for 5 cycles after lane 1's first word -> no push in those cycles; words 2-4 pushed after full drops, data unchanged.
REQ-034 Lane 3 owner drops req after 1 word -> stall_err pulses after 16 idle cycles; lane 0 granted next.
REQ-035 Reset pulsed mid-burst -> push drops immediately, clr for one cycle, arbitration restarts from lane 0.
